// File: rtl/alarm_pkg.sv
// Shared types for the vehicle alarm controller: FSM state encoding,
// timing-parameter select codes and small helpers for timer selection.
package alarm_pkg;

    typedef enum logic [2:0] {
        ARMED           = 3'd0,
        TRIGGERED       = 3'd1,
        ALARM           = 3'd2,
        DISARMED        = 3'd3,
        WAIT_DOOR_OPEN  = 3'd4,
        WAIT_DOOR_CLOSE = 3'd5,
        ARM_DELAY       = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEL_ARM = 2'b00,
        SEL_DRV = 2'b01,
        SEL_PAS = 2'b10,
        SEL_ALM = 2'b11
    } sel_t;

    localparam int NUM_PARAMS = 4;

    // States whose behaviour depends on the countdown.
    function automatic logic is_timed(state_t s);
        return (s == TRIGGERED) || (s == ALARM) || (s == ARM_DELAY);
    endfunction

    // Parameter that governs the countdown of a timed state. In TRIGGERED
    // it depends on which door caused the trigger.
    function automatic sel_t gov_sel(state_t s, logic trig_drv);
        sel_t r;
        case (s)
            TRIGGERED: r = trig_drv ? SEL_DRV : SEL_PAS;
            ALARM:     r = SEL_ALM;
            default:   r = SEL_ARM;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alarm_ctrl_multi_sec_timer.sv
// Seconds tick divider plus loadable down-counter. A load (or hold) writes
// the counter and restarts the divider, so the first decrement after a load
// comes a full second later. expired is combinational on count==0.
module sec_timer #(
    parameter int TIME_W      = 4,
    parameter int CLK_PER_SEC = 100000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              hold_i,
    input  logic [TIME_W-1:0] load_val_i,
    output logic              tick_o,
    output logic              expired_o,
    output logic [TIME_W-1:0] count_o
);

    localparam int TW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    logic [TW-1:0]     tick_cnt_q;
    logic [TIME_W-1:0] count_q;

    assign tick_o    = (tick_cnt_q == TW'(CLK_PER_SEC - 1));
    assign expired_o = (count_q == '0);
    assign count_o   = count_q;

    // Divider and countdown; hold keeps the counter pinned at load_val.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
            count_q    <= '0;
        end else if (load_i || hold_i) begin
            tick_cnt_q <= '0;
            count_q    <= load_val_i;
        end else if (tick_o) begin
            tick_cnt_q <= '0;
            if (count_q != '0) begin
                count_q <= count_q - TIME_W'(1);
            end
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/alarm_ctrl_multi.sv
// Anti-theft controller: timing register file, arm/trigger/alarm FSM,
// hidden-switch fuel-pump interlock and status LED blink. All outputs are
// registered. The pedal input is named brake since break is reserved.
module alarm_ctrl_multi
    import alarm_pkg::*;
#(
    parameter int NUM_DOORS   = 2,
    parameter int TIME_W      = 4,
    parameter int CLK_PER_SEC = 100000000,
    parameter int T_ARM_DEF   = 6,
    parameter int T_DRV_DEF   = 8,
    parameter int T_PAS_DEF   = 15,
    parameter int T_ALM_DEF   = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 brake,
    input  logic                 hidden_sw,
    input  logic                 ignition,
    input  logic [NUM_DOORS-1:0] doors,
    input  logic                 reprogram,
    input  logic [1:0]           time_param_sel,
    input  logic [TIME_W-1:0]    time_value,
    output logic                 fuel_pump,
    output logic                 siren,
    output logic                 status,
    output logic [2:0]           state_o,
    output logic [TIME_W-1:0]    count_o
);

    logic [TIME_W-1:0] params_q [NUM_PARAMS];

    state_t            state_q, state_d;
    logic              trig_drv_q, trig_drv_d;
    logic              siren_q, status_q, status_d;
    logic              blink_q, blink_d;
    logic              fuel_q;

    logic              tmr_load, tmr_hold, sec_tick, expired;
    logic [TIME_W-1:0] tmr_val, reload_val, tmr_count;
    logic              driver_open, pass_open, any_open;
    sel_t              gsel;

    assign driver_open = doors[0];
    assign pass_open   = |doors[NUM_DOORS-1:1];
    assign any_open    = |doors;

    sec_timer #(
        .TIME_W      (TIME_W),
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .hold_i     (tmr_hold),
        .load_val_i (tmr_val),
        .tick_o     (sec_tick),
        .expired_o  (expired),
        .count_o    (tmr_count)
    );

    // Reload value on reprogram: the (possibly just-written) parameter that
    // governs the current state, or 0 if the state is not timed.
    always_comb begin
        gsel       = gov_sel(state_q, trig_drv_q);
        reload_val = '0;
        if (is_timed(state_q)) begin
            reload_val = (time_param_sel == gsel) ? time_value : params_q[gsel];
        end
    end

    // Next state and timer control; reprogram overrides every transition.
    always_comb begin
        state_d    = state_q;
        trig_drv_d = trig_drv_q;
        tmr_load   = 1'b0;
        tmr_hold   = 1'b0;
        tmr_val    = '0;
        if (reprogram) begin
            state_d  = ARMED;
            tmr_load = 1'b1;
            tmr_val  = reload_val;
        end else begin
            case (state_q)
                ARMED: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (driver_open) begin
                        state_d    = TRIGGERED;
                        trig_drv_d = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = params_q[SEL_DRV];
                    end else if (pass_open) begin
                        state_d    = TRIGGERED;
                        trig_drv_d = 1'b0;
                        tmr_load   = 1'b1;
                        tmr_val    = params_q[SEL_PAS];
                    end
                end
                TRIGGERED: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (expired) begin
                        state_d  = ALARM;
                        tmr_load = 1'b1;
                        tmr_val  = params_q[SEL_ALM];
                    end
                end
                ALARM: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (any_open) begin
                        tmr_hold = 1'b1;
                        tmr_val  = params_q[SEL_ALM];
                    end else if (expired) begin
                        state_d = ARMED;
                    end
                end
                DISARMED: begin
                    if (!ignition) begin
                        state_d = WAIT_DOOR_OPEN;
                    end
                end
                WAIT_DOOR_OPEN: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (driver_open) begin
                        state_d = WAIT_DOOR_CLOSE;
                    end
                end
                WAIT_DOOR_CLOSE: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (!any_open) begin
                        state_d  = ARM_DELAY;
                        tmr_load = 1'b1;
                        tmr_val  = params_q[SEL_ARM];
                    end
                end
                ARM_DELAY: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (any_open) begin
                        state_d = WAIT_DOOR_CLOSE;
                    end else if (expired) begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
        end
    end

    // Blink phase restarts at 1 outside ARMED; toggles on each tick while armed.
    always_comb begin
        blink_d = blink_q;
        if (state_d != ARMED) begin
            blink_d = 1'b1;
        end else if ((state_q == ARMED) && sec_tick) begin
            blink_d = ~blink_q;
        end
        case (state_d)
            ARMED:           status_d = blink_d;
            TRIGGERED, ALARM: status_d = 1'b1;
            default:         status_d = 1'b0;
        endcase
    end

    // Timing register file, written by reprogram pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            params_q[SEL_ARM] <= TIME_W'(T_ARM_DEF);
            params_q[SEL_DRV] <= TIME_W'(T_DRV_DEF);
            params_q[SEL_PAS] <= TIME_W'(T_PAS_DEF);
            params_q[SEL_ALM] <= TIME_W'(T_ALM_DEF);
        end else if (reprogram) begin
            params_q[time_param_sel] <= time_value;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARMED;
            trig_drv_q <= 1'b0;
            siren_q    <= 1'b0;
            status_q   <= 1'b1;
            blink_q    <= 1'b1;
            fuel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_drv_q <= trig_drv_d;
            siren_q    <= (state_d == ALARM);
            status_q   <= status_d;
            blink_q    <= blink_d;
            fuel_q     <= ignition ? (fuel_q | (brake & hidden_sw)) : 1'b0;
        end
    end

    assign fuel_pump = fuel_q;
    assign siren     = siren_q;
    assign status    = status_q;
    assign state_o   = state_q;
    assign count_o   = tmr_count;

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Directed bench for alarm_ctrl_multi with a one-second tick of 4 clocks.
module tb_alarm_ctrl_multi;
  import alarm_pkg::*;

  localparam int ND = 2;
  localparam int TW = 4;
  localparam int EW = 3 + TW + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          brake, hidden_sw, ignition, reprogram;
  logic [ND-1:0] doors;
  logic [1:0]    time_param_sel;
  logic [TW-1:0] time_value;
  logic          fuel_pump, siren, status;
  logic [2:0]    state_o;
  logic [TW-1:0] count_o;

  alarm_ctrl_multi #(
    .NUM_DOORS   (ND),
    .TIME_W      (TW),
    .CLK_PER_SEC (4)
  ) dut (
    .clock          (clk),
    .reset          (rst),
    .brake          (brake),
    .hidden_sw      (hidden_sw),
    .ignition       (ignition),
    .doors          (doors),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .fuel_pump      (fuel_pump),
    .siren          (siren),
    .status         (status),
    .state_o        (state_o),
    .count_o        (count_o)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] msk_q[$];
  string         name_q[$];
  int checks = 0;
  int errors = 0;

  // Expected vector layout: {state, count, siren, status, fuel_pump}.
  task automatic chk(input string nm, input logic [2:0] st, input logic [TW-1:0] cnt,
                     input logic sir, input logic sts, input logic fp,
                     input logic use_cnt, input logic use_sts);
    logic [EW-1:0] m;
    m = '1;
    if (!use_cnt) m[3 +: TW] = '0;
    if (!use_sts) m[1] = 1'b0;
    exp_q.push_back({st, cnt, sir, sts, fp});
    msk_q.push_back(m);
    name_q.push_back(nm);
  endtask

  // Monitor: compares every pending expectation on the falling edge.
  always @(negedge clk) begin
    logic [EW-1:0] e, m, act;
    string nm;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      m   = msk_q.pop_front();
      nm  = name_q.pop_front();
      act = {state_o, count_o, siren, status, fuel_pump};
      checks++;
      if ((act & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s: got st=%0d cnt=%0d siren=%0b status=%0b fp=%0b, want st=%0d cnt=%0d siren=%0b status=%0b fp=%0b (mask %b)",
                 nm, act[EW-1 -: 3], act[3 +: TW], act[2], act[1], act[0],
                 e[EW-1 -: 3], e[3 +: TW], e[2], e[1], e[0], m);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reprog(input logic [1:0] sel, input logic [TW-1:0] val);
    reprogram      = 1'b1;
    time_param_sel = sel;
    time_value     = val;
    step(1);
    reprogram      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; brake = 0; hidden_sw = 0; ignition = 0; reprogram = 0;
    doors = '0; time_param_sel = '0; time_value = '0;
    step(2);
    rst = 1'b0;
    chk("reset", ARMED, 0, 0, 1, 0, 1, 1);

    // Passenger trigger, alarm with a door held open, countdown back to ARMED.
    doors = 2'b10;
    step(1);  doors = 2'b00;
    chk("pas_trig", TRIGGERED, 15, 0, 1, 0, 1, 1);
    step(4);  chk("pas_tick1", TRIGGERED, 14, 0, 1, 0, 1, 1);
    doors = 2'b10;
    step(4);  chk("trig_no_reload", TRIGGERED, 13, 0, 1, 0, 1, 1);
    step(51); chk("pas_cnt1", TRIGGERED, 1, 0, 1, 0, 1, 1);
    step(1);  chk("pas_cnt0", TRIGGERED, 0, 0, 1, 0, 1, 1);
    step(1);  chk("alarm_entry", ALARM, 10, 1, 1, 0, 1, 1);
    step(20); chk("alarm_hold", ALARM, 10, 1, 1, 0, 1, 1);
    doors = 2'b00;
    step(39); chk("alarm_cnt1", ALARM, 1, 1, 1, 0, 1, 1);
    step(1);  chk("alarm_cnt0", ALARM, 0, 1, 1, 0, 1, 1);
    step(1);  chk("alarm_done", ARMED, 0, 0, 1, 0, 1, 1);

    // Driver trigger, ignition disarms, fuel-pump interlock.
    doors = 2'b01;
    step(1);  doors = 2'b00;
    chk("drv_trig", TRIGGERED, 8, 0, 1, 0, 1, 1);
    step(20); chk("drv_5s", TRIGGERED, 3, 0, 1, 0, 1, 1);
    ignition = 1'b1;
    step(1);  chk("disarm", DISARMED, 0, 0, 0, 0, 0, 1);
    brake = 1'b1; hidden_sw = 1'b1;
    step(1);  chk("fp_set", DISARMED, 0, 0, 0, 1, 0, 1);
    brake = 1'b0; hidden_sw = 1'b0;
    step(1);  chk("fp_latched", DISARMED, 0, 0, 0, 1, 0, 1);
    ignition = 1'b0;
    step(1);  chk("fp_clear", WAIT_DOOR_OPEN, 0, 0, 0, 0, 0, 1);

    // Re-arm sequence with an interrupted arming delay.
    doors = 2'b01;
    step(1);  chk("wdc", WAIT_DOOR_CLOSE, 0, 0, 0, 0, 0, 1);
    doors = 2'b00;
    step(1);  chk("arm_delay", ARM_DELAY, 6, 0, 0, 0, 1, 1);
    step(12); chk("arm_delay_3s", ARM_DELAY, 3, 0, 0, 0, 1, 1);
    doors = 2'b10;
    step(1);  chk("arm_reopen", WAIT_DOOR_CLOSE, 0, 0, 0, 0, 0, 1);
    doors = 2'b00;
    step(1);  chk("arm_reload", ARM_DELAY, 6, 0, 0, 0, 1, 1);
    step(23); chk("arm_cnt1", ARM_DELAY, 1, 0, 0, 0, 1, 1);
    step(1);  chk("arm_cnt0", ARM_DELAY, 0, 0, 0, 0, 1, 1);
    step(1);  chk("armed_again", ARMED, 0, 0, 1, 0, 1, 1);
    step(2);  chk("blink_hi", ARMED, 0, 0, 1, 0, 1, 1);
    step(1);  chk("blink_lo", ARMED, 0, 0, 0, 0, 1, 1);
    step(4);  chk("blink_hi2", ARMED, 0, 0, 1, 0, 1, 1);

    // Reprogrammed driver delay of 3 s, then 0 s.
    reprog(2'b01, 4'd3);
    chk("reprog_armed", ARMED, 0, 0, 1, 0, 1, 1);
    doors = 2'b01;
    step(1);  doors = 2'b00;
    chk("drv3_trig", TRIGGERED, 3, 0, 1, 0, 1, 1);
    step(11); chk("drv3_cnt1", TRIGGERED, 1, 0, 1, 0, 1, 1);
    step(1);  chk("drv3_cnt0", TRIGGERED, 0, 0, 1, 0, 1, 1);
    step(1);  chk("drv3_alarm", ALARM, 10, 1, 1, 0, 1, 1);
    reprog(2'b01, 4'd0);
    chk("reprog_in_alarm", ARMED, 10, 0, 1, 0, 1, 1);
    doors = 2'b01;
    step(1);  doors = 2'b00;
    chk("drv0_trig", TRIGGERED, 0, 0, 1, 0, 1, 1);
    step(1);  chk("drv0_alarm", ALARM, 10, 1, 1, 0, 1, 1);

    // Reset mid-TRIGGERED restores defaults.
    reprog(2'b01, 4'd5);
    chk("reprog_drv5", ARMED, 10, 0, 1, 0, 1, 1);
    doors = 2'b10;
    step(1);  doors = 2'b00;
    chk("pas_trig2", TRIGGERED, 15, 0, 1, 0, 1, 1);
    step(3);  chk("pas_trig2_hold", TRIGGERED, 15, 0, 1, 0, 1, 1);
    rst = 1'b1;
    step(1);  rst = 1'b0;
    chk("mid_reset", ARMED, 0, 0, 1, 0, 1, 1);
    doors = 2'b01;
    step(1);  doors = 2'b00;
    chk("drv_default", TRIGGERED, 8, 0, 1, 0, 1, 1);

    step(2);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      errors += exp_q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
